// File: rtl/fwd_pkg.sv
// Shared constants for the operand bypass network: select encodings and the
// bit layout of one in-flight producer tag entry.
package fwd_pkg;

  localparam int unsigned SEL_RF = 0;

  // Tag entry layout: {rd, isload, valid}, valid in bit 0.
  localparam int unsigned TAG_VALID_BIT  = 0;
  localparam int unsigned TAG_ISLOAD_BIT = 1;
  localparam int unsigned TAG_RD_LSB     = 2;

  function automatic int unsigned tag_w(input int unsigned regw);
    return regw + TAG_RD_LSB;
  endfunction

  // SEL_ZERO depends on the tracked depth, so it is derived per instance.
  function automatic int unsigned sel_zero(input int unsigned depth);
    return depth + 1;
  endfunction

endpackage

// File: rtl/operand_forward_unit_if.sv
// Issue/bypass bus between the ID stage and the EX-stage operand forwarding unit.
interface operand_forward_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REGW  = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned NOPS  = 2,
  parameter int unsigned CNTW  = 16,
  parameter int unsigned SELW  = $clog2(DEPTH + 2)
);

  logic                   issue_valid_i;
  logic [NOPS*REGW-1:0]   issue_rs_i;
  logic [REGW-1:0]        issue_rd_i;
  logic                   issue_regwrite_i;
  logic                   issue_isload_i;
  logic                   flush_i;
  logic [NOPS*XLEN-1:0]   rf_data_i;
  logic [DEPTH*XLEN-1:0]  stage_data_i;
  logic                   stall_o;
  logic                   op_valid_o;
  logic [NOPS*XLEN-1:0]   op_data_o;
  logic [NOPS*SELW-1:0]   fwd_sel_o;
  logic [CNTW-1:0]        stall_cnt_o;

  modport master (
    output issue_valid_i, issue_rs_i, issue_rd_i, issue_regwrite_i, issue_isload_i,
    output flush_i, rf_data_i, stage_data_i,
    input  stall_o, op_valid_o, op_data_o, fwd_sel_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid_i, issue_rs_i, issue_rd_i, issue_regwrite_i, issue_isload_i,
    input  flush_i, rf_data_i, stage_data_i,
    output stall_o, op_valid_o, op_data_o, fwd_sel_o, stall_cnt_o
  );

endinterface

// File: rtl/fwd_operand_sel.sv
// Priority tag match and bypass mux for a single source operand; the youngest
// matching producer wins and flags a load-use hazard if its data is not ready.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned SELW     = $clog2(DEPTH + 2)
) (
  input  logic [REGW-1:0]       rs_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic [DEPTH*XLEN-1:0] stage_data_i,
  input  logic [DEPTH-1:0]      tag_valid_i,
  input  logic [DEPTH*REGW-1:0] tag_rd_i,
  input  logic [DEPTH-1:0]      tag_isload_i,
  output logic [XLEN-1:0]       data_o,
  output logic [SELW-1:0]       sel_o,
  output logic                  hazard_o
);

  logic found;

  always_comb begin
    data_o   = rf_data_i;
    sel_o    = SELW'(SEL_RF);
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && tag_valid_i[i] && (tag_rd_i[i*REGW +: REGW] == rs_i)) begin
        found    = 1'b1;
        data_o   = stage_data_i[i*XLEN +: XLEN];
        sel_o    = SELW'(i + 1);
        hazard_o = tag_isload_i[i] && (i < LOAD_LAT);
      end
    end
    // x0 reads as zero regardless of any producer tagged x0.
    if (rs_i == '0) begin
      data_o   = '0;
      sel_o    = SELW'(sel_zero(DEPTH));
      hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// EX-stage operand bypass network: tracks in-flight producer tags, forwards the
// youngest match per operand, stalls on load-use hazards and counts stall cycles.
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned NOPS     = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNTW     = 16,
  parameter int unsigned SELW     = $clog2(DEPTH + 2)
) (
  input logic              clk_i,
  input logic              rst_i,
  operand_forward_unit_if.slave bus
);

  localparam int unsigned TagW = tag_w(REGW);

  logic [DEPTH-1:0][TagW-1:0] tag_q, tag_d;
  logic [DEPTH-1:0]           tag_valid;
  logic [DEPTH-1:0]           tag_isload;
  logic [DEPTH*REGW-1:0]      tag_rd;

  logic [NOPS*XLEN-1:0] op_data_sel;
  logic [NOPS*SELW-1:0] fwd_sel_sel;
  logic [NOPS-1:0]      hazard;
  logic                 stall;
  logic                 issue;

  logic                 op_valid_q, op_valid_d;
  logic [NOPS*XLEN-1:0] op_data_q, op_data_d;
  logic [NOPS*SELW-1:0] fwd_sel_q, fwd_sel_d;
  logic [CNTW-1:0]      stall_cnt_q, stall_cnt_d;

  always_comb begin
    tag_valid  = '0;
    tag_isload = '0;
    tag_rd     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tag_valid[i]              = tag_q[i][TAG_VALID_BIT];
      tag_isload[i]             = tag_q[i][TAG_ISLOAD_BIT];
      tag_rd[i*REGW +: REGW]    = tag_q[i][TAG_RD_LSB +: REGW];
    end
  end

  for (genvar k = 0; k < NOPS; k++) begin : g_op
    fwd_operand_sel #(
      .XLEN     (XLEN),
      .REGW     (REGW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SELW     (SELW)
    ) u_sel (
      .rs_i         (bus.issue_rs_i[k*REGW +: REGW]),
      .rf_data_i    (bus.rf_data_i[k*XLEN +: XLEN]),
      .stage_data_i (bus.stage_data_i),
      .tag_valid_i  (tag_valid),
      .tag_rd_i     (tag_rd),
      .tag_isload_i (tag_isload),
      .data_o       (op_data_sel[k*XLEN +: XLEN]),
      .sel_o        (fwd_sel_sel[k*SELW +: SELW]),
      .hazard_o     (hazard[k])
    );
  end

  // Flush dominates a hazard: the squashed instruction never waits.
  assign stall = bus.issue_valid_i && !bus.flush_i && (|hazard);
  assign issue = bus.issue_valid_i && !stall && !bus.flush_i;

  always_comb begin
    tag_d    = '0;
    tag_d[0][TAG_VALID_BIT]       = issue && bus.issue_regwrite_i && (bus.issue_rd_i != '0);
    tag_d[0][TAG_ISLOAD_BIT]      = bus.issue_isload_i;
    tag_d[0][TAG_RD_LSB +: REGW]  = bus.issue_rd_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    op_valid_d  = issue;
    op_data_d   = issue ? op_data_sel : op_data_q;
    fwd_sel_d   = issue ? fwd_sel_sel : fwd_sel_q;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tag_q       <= '0;
      op_valid_q  <= 1'b0;
      op_data_q   <= '0;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      tag_q       <= tag_d;
      op_valid_q  <= op_valid_d;
      op_data_q   <= op_data_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.op_valid_o  = op_valid_q;
  assign bus.op_data_o   = op_data_q;
  assign bus.fwd_sel_o   = fwd_sel_q;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed and randomized checks of operand_forward_unit against a queue-based
// reference model of in-flight producers.
module tb_operand_forward_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REGW     = 5;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned NOPS     = 2;
  localparam int unsigned LOAD_LAT = 1;
  localparam int unsigned CNTW     = 16;
  localparam int unsigned SELW     = $clog2(DEPTH + 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_forward_unit_if #(
    .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .NOPS(NOPS), .CNTW(CNTW), .SELW(SELW)
  ) bus ();

  operand_forward_unit #(
    .XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .NOPS(NOPS), .LOAD_LAT(LOAD_LAT),
    .CNTW(CNTW), .SELW(SELW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus for the current cycle.
  logic            in_valid, in_rw, in_ld, in_flush;
  logic [REGW-1:0] in_rs [NOPS];
  logic [REGW-1:0] in_rd;
  logic [XLEN-1:0] in_rf [NOPS];
  logic [XLEN-1:0] in_sd [DEPTH];

  // Reference model: producers in flight, index 0 = issued one cycle ago.
  typedef struct {
    bit valid;
    int rd;
    bit isload;
  } prod_t;
  prod_t           inflight[$];
  bit              m_op_valid;
  logic [XLEN-1:0] m_op_data [NOPS];
  int              m_sel [NOPS];
  longint          m_cnt;
  logic            obs_stall;

  task automatic model_reset();
    prod_t p;
    p.valid = 0; p.rd = 0; p.isload = 0;
    inflight.delete();
    for (int i = 0; i < DEPTH; i++) inflight.push_back(p);
    m_op_valid = 0;
    m_cnt      = 0;
    for (int k = 0; k < NOPS; k++) begin
      m_op_data[k] = '0;
      m_sel[k]     = 0;
    end
  endtask

  task automatic ref_sel(input int k, output logic [XLEN-1:0] d, output int s, output bit hz);
    d  = in_rf[k];
    s  = 0;
    hz = 0;
    if (in_rs[k] == 0) begin
      d = '0;
      s = DEPTH + 1;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (inflight[i].valid && inflight[i].rd == int'(in_rs[k])) begin
        d  = in_sd[i];
        s  = i + 1;
        hz = inflight[i].isload && (i < LOAD_LAT);
        return;
      end
    end
  endtask

  task automatic apply();
    bus.issue_valid_i    = in_valid;
    bus.issue_rd_i       = in_rd;
    bus.issue_regwrite_i = in_rw;
    bus.issue_isload_i   = in_ld;
    bus.flush_i          = in_flush;
    for (int k = 0; k < NOPS; k++) begin
      bus.issue_rs_i[k*REGW +: REGW] = in_rs[k];
      bus.rf_data_i[k*XLEN +: XLEN]  = in_rf[k];
    end
    for (int i = 0; i < DEPTH; i++) bus.stage_data_i[i*XLEN +: XLEN] = in_sd[i];
  endtask

  // One clock: drive, check the combinational stall, clock, update model, check registers.
  task automatic step();
    logic [XLEN-1:0] d [NOPS];
    int              s [NOPS];
    bit              hz_any, hz, exp_stall, exp_issue;
    prod_t           p;
    apply();
    #1;
    hz_any = 0;
    for (int k = 0; k < NOPS; k++) begin
      ref_sel(k, d[k], s[k], hz);
      hz_any |= hz;
    end
    exp_stall = in_valid && !in_flush && hz_any;
    exp_issue = in_valid && !exp_stall && !in_flush;
    obs_stall = bus.stall_o;
    check_eq("stall", 64'(bus.stall_o), 64'(exp_stall));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_op_valid = exp_issue;
      if (exp_issue) begin
        for (int k = 0; k < NOPS; k++) begin
          m_op_data[k] = d[k];
          m_sel[k]     = s[k];
        end
      end
      if (exp_stall && m_cnt < (64'd1 << CNTW) - 1) m_cnt++;
      p.valid  = exp_issue && in_rw && (in_rd != 0);
      p.rd     = int'(in_rd);
      p.isload = in_ld;
      inflight.push_front(p);
      void'(inflight.pop_back());
    end
    #1;
    check_eq("op_valid", 64'(bus.op_valid_o), 64'(m_op_valid));
    for (int k = 0; k < NOPS; k++) begin
      check_eq($sformatf("op_data%0d", k), 64'(bus.op_data_o[k*XLEN +: XLEN]), 64'(m_op_data[k]));
      check_eq($sformatf("fwd_sel%0d", k), 64'(bus.fwd_sel_o[k*SELW +: SELW]), 64'(m_sel[k]));
    end
    check_eq("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_cnt));
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_valid = 0; in_rw = 0; in_ld = 0; in_flush = 0; in_rd = '0;
    for (int k = 0; k < NOPS; k++) begin
      in_rs[k] = '0;
      in_rf[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) in_sd[i] = '0;
  endtask

  task automatic set_instr(input int rs0, input int rs1, input int rd, input bit rw, input bit ld);
    in_valid = 1; in_flush = 0;
    in_rs[0] = REGW'(rs0); in_rs[1] = REGW'(rs1);
    in_rd = REGW'(rd); in_rw = rw; in_ld = ld;
  endtask

  initial begin
    model_reset();
    set_idle();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    check_eq("reset_cnt", 64'(bus.stall_cnt_o), 64'd0);
    check_eq("reset_valid", 64'(bus.op_valid_o), 64'd0);

    // No producers: register-file operand.
    set_instr(3, 4, 0, 0, 0);
    in_rf[0] = 32'h11;
    step();
    check_eq("t1_data", 64'(bus.op_data_o[0 +: XLEN]), 64'h11);
    check_eq("t1_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'd0);
    check_eq("t1_valid", 64'(bus.op_valid_o), 64'd1);

    // ADD x5, then consumer that also writes x5, then youngest-wins consumer.
    set_instr(1, 2, 5, 1, 0);
    step();
    set_instr(5, 0, 5, 1, 0);
    in_sd[0] = 32'hAA;
    step();
    check_eq("t2_stall", 64'(obs_stall), 64'd0);
    check_eq("t2_data", 64'(bus.op_data_o[0 +: XLEN]), 64'hAA);
    check_eq("t2_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'd1);
    set_instr(5, 6, 0, 0, 0);
    in_sd[0] = 32'hAA; in_sd[1] = 32'hBB;
    step();
    check_eq("t3_data", 64'(bus.op_data_o[0 +: XLEN]), 64'hAA);
    check_eq("t3_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'd1);

    // Load-use: one stall cycle, then forward from stage 1.
    set_instr(1, 2, 7, 1, 1);
    step();
    set_instr(7, 0, 0, 0, 0);
    step();
    check_eq("t4_stall", 64'(obs_stall), 64'd1);
    check_eq("t4_cnt", 64'(bus.stall_cnt_o), 64'd1);
    in_sd[1] = 32'h77;
    step();
    check_eq("t4_stall2", 64'(obs_stall), 64'd0);
    check_eq("t4_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'd2);
    check_eq("t4_data", 64'(bus.op_data_o[0 +: XLEN]), 64'h77);

    // x0 producer must not forward.
    set_instr(1, 2, 0, 1, 0);
    step();
    set_instr(0, 0, 0, 0, 0);
    in_sd[0] = 32'hDEAD; in_rf[0] = 32'h55;
    step();
    check_eq("t5_data", 64'(bus.op_data_o[0 +: XLEN]), 64'd0);
    check_eq("t5_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'(DEPTH + 1));

    // Flush beats hazard; reset during a stall clears everything.
    set_instr(1, 2, 9, 1, 1);
    step();
    set_instr(9, 0, 0, 0, 0);
    in_flush = 1;
    step();
    check_eq("t6_stall", 64'(obs_stall), 64'd0);
    check_eq("t6_valid", 64'(bus.op_valid_o), 64'd0);
    set_instr(1, 2, 9, 1, 1);
    step();
    set_instr(9, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    check_eq("t6_rst_stall", 64'(obs_stall), 64'd1);
    check_eq("t6_rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
    check_eq("t6_rst_data", 64'(bus.op_data_o), 64'd0);
    rst_n = 1'b1;
    in_rf[0] = 32'h99; in_sd[0] = 32'h1; in_sd[1] = 32'h2;
    step();
    check_eq("t6_post_sel", 64'(bus.fwd_sel_o[0 +: SELW]), 64'd0);
    check_eq("t6_post_data", 64'(bus.op_data_o[0 +: XLEN]), 64'h99);

    // Randomized traffic over a small register set to force frequent matches.
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_flush = ($urandom_range(0, 7) == 0);
      in_rw    = ($urandom_range(0, 3) != 0);
      in_ld    = ($urandom_range(0, 2) == 0);
      in_rd    = REGW'($urandom_range(0, 7));
      for (int k = 0; k < NOPS; k++) begin
        in_rs[k] = REGW'($urandom_range(0, 7));
        in_rf[k] = $urandom;
      end
      for (int i = 0; i < DEPTH; i++) in_sd[i] = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
